// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - channel state type and index sizing helper for mem_request_controller
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } channel_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin first-set finder, scanning from ptr+1 modulo N
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [IW-1:0] idx,
    output logic          found
);

    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // i runs to N so the pointer's own slot is the last one considered
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(ptr) + i) % N;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx] && !excl[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_request_controller.sv
// rtl/mem_request_controller.sv - arbitrates consumer read/write requests onto memory channels
// Optional MEM_CTRL_PERF_EN adds saturating perf_requests / perf_stall_cycles counters.
module mem_request_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0]                              perf_requests,
    output logic [31:0]                              perf_stall_cycles
`endif
);

    localparam int IW = idx_width(NUM_CONSUMERS);

    channel_state_t state_q [NUM_CHANNELS];
    channel_state_t state_d [NUM_CHANNELS];
    logic [IW-1:0]  idx_q   [NUM_CHANNELS];
    logic [IW-1:0]  rr_q    [NUM_CHANNELS];
    logic [IW-1:0]  pick_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pick_found;
    logic [NUM_CHANNELS-1:0] op_wr_q;

    logic [NUM_CHANNELS-1:0] grant, grant_rd, rd_done, wr_done, release_ch;

    logic [NUM_CONSUMERS-1:0] claim_q;
    logic [NUM_CONSUMERS-1:0] req_mask;
    logic [NUM_CONSUMERS-1:0] write_ready_q;
    logic [NUM_CHANNELS-1:0]  mem_write_valid_q;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address_q;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data_q;

    // A read-only instance never sees write requests, so WRITE_WAITING stays unreachable
    assign req_mask = consumer_read_valid
                    | ((WRITE_ENABLE != 0) ? consumer_write_valid : '0);

    // Each channel excludes consumers already claimed or granted by a lower channel this cycle
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] excl_in;
        logic [NUM_CONSUMERS-1:0] excl_out;
        logic [IW-1:0]            idx;
        logic                     found;

        if (c == 0) begin : g_first
            assign excl_in = claim_q;
        end else begin : g_next
            assign excl_in = g_ch[c-1].excl_out;
        end

        rr_picker #(
            .N  (NUM_CONSUMERS),
            .IW (IW)
        ) u_pick (
            .req   (req_mask),
            .ptr   (rr_q[c]),
            .excl  (excl_in),
            .idx   (idx),
            .found (found)
        );

        assign excl_out = excl_in
                        | ((state_q[c] == IDLE && found) ? (NUM_CONSUMERS'(1) << idx) : '0);
        assign pick_idx[c]   = idx;
        assign pick_found[c] = found;
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c]    = state_q[c];
            grant[c]      = 1'b0;
            grant_rd[c]   = 1'b0;
            rd_done[c]    = 1'b0;
            wr_done[c]    = 1'b0;
            release_ch[c] = 1'b0;
            case (state_q[c])
                IDLE: begin
                    if (pick_found[c]) begin
                        grant[c]    = 1'b1;
                        grant_rd[c] = consumer_read_valid[pick_idx[c]];
                        state_d[c]  = grant_rd[c] ? READ_WAITING : WRITE_WAITING;
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        rd_done[c] = 1'b1;
                        state_d[c] = RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[c]) begin
                        wr_done[c] = 1'b1;
                        state_d[c] = RELAYING;
                    end
                end
                RELAYING: begin
                    if (op_wr_q[c] ? !consumer_write_valid[idx_q[c]]
                                   : !consumer_read_valid[idx_q[c]]) begin
                        release_ch[c] = 1'b1;
                        state_d[c]    = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
                idx_q[c]   <= '0;
                rr_q[c]    <= '0;
            end
            op_wr_q             <= '0;
            claim_q             <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            write_ready_q       <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            mem_write_valid_q   <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                if (grant[c]) begin
                    idx_q[c]              <= pick_idx[c];
                    rr_q[c]               <= pick_idx[c];
                    claim_q[pick_idx[c]]  <= 1'b1;
                    op_wr_q[c]            <= !grant_rd[c];
                    if (grant_rd[c]) begin
                        mem_read_valid[c]   <= 1'b1;
                        mem_read_address[c] <= consumer_read_address[pick_idx[c]];
                    end else begin
                        mem_write_valid_q[c]   <= 1'b1;
                        mem_write_address_q[c] <= consumer_write_address[pick_idx[c]];
                        mem_write_data_q[c]    <= consumer_write_data[pick_idx[c]];
                    end
                end
                // Valid drops on the edge that sees ready, so the responder never re-serves
                if (rd_done[c]) begin
                    mem_read_valid[c]                <= 1'b0;
                    consumer_read_data[idx_q[c]]     <= mem_read_data[c];
                    consumer_read_ready[idx_q[c]]    <= 1'b1;
                end
                if (wr_done[c]) begin
                    mem_write_valid_q[c]      <= 1'b0;
                    write_ready_q[idx_q[c]]   <= 1'b1;
                end
                if (release_ch[c]) begin
                    claim_q[idx_q[c]] <= 1'b0;
                    if (op_wr_q[c]) begin
                        write_ready_q[idx_q[c]] <= 1'b0;
                    end else begin
                        consumer_read_ready[idx_q[c]] <= 1'b0;
                    end
                end
            end
        end
    end

    assign consumer_write_ready = (WRITE_ENABLE != 0) ? write_ready_q       : '0;
    assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_write_valid_q   : '0;
    assign mem_write_address    = (WRITE_ENABLE != 0) ? mem_write_address_q : '0;
    assign mem_write_data       = (WRITE_ENABLE != 0) ? mem_write_data_q    : '0;

`ifdef MEM_CTRL_PERF_EN
    logic [31:0] req_inc;
    logic        stall_now;

    // Every completion raises exactly one consumer ready on the same edge
    assign req_inc   = 32'($countones(rd_done | wr_done));
    assign stall_now = |(req_mask & ~claim_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_requests     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (perf_requests > (32'hFFFF_FFFF - req_inc)) begin
                perf_requests <= 32'hFFFF_FFFF;
            end else begin
                perf_requests <= perf_requests + req_inc;
            end
            if (stall_now && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_request_controller.sv
// tb/tb_mem_request_controller.sv - directed bench for mem_request_controller with a 1-cycle memory responder
module tb_mem_request_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] mem [256];

    // Instance A: 4 consumers, 1 channel, writes enabled
    logic [3:0]        a_rv, a_rr, a_wv, a_wr;
    logic [3:0][7:0]   a_ra, a_wa;
    logic [3:0][15:0]  a_rd, a_wd;
    logic [0:0]        a_mrv, a_mrr, a_mwv, a_mwr;
    logic [0:0][7:0]   a_mra, a_mwa;
    logic [0:0][15:0]  a_mrd, a_mwd;
    logic              a_stall;
    int                a_reads;
    logic [7:0]        a_log [256];

    // Instance B: 4 consumers, 2 channels
    logic [3:0]        b_rv, b_rr, b_wv, b_wr;
    logic [3:0][7:0]   b_ra, b_wa;
    logic [3:0][15:0]  b_rd, b_wd;
    logic [1:0]        b_mrv, b_mrr, b_mwv, b_mwr;
    logic [1:0][7:0]   b_mra, b_mwa;
    logic [1:0][15:0]  b_mrd, b_mwd;

    // Instance C: read-only
    logic [3:0]        c_rv, c_rr, c_wv, c_wr;
    logic [3:0][7:0]   c_ra, c_wa;
    logic [3:0][15:0]  c_rd, c_wd;
    logic [0:0]        c_mrv, c_mrr, c_mwv, c_mwr;
    logic [0:0][7:0]   c_mra, c_mwa;
    logic [0:0][15:0]  c_mrd, c_mwd;

    mem_request_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(1)) u_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
        .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
        .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    mem_request_controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(1)) u_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
        .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
        .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    mem_request_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) u_c (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(c_mrv), .mem_read_address(c_mra),
        .mem_read_ready(c_mrr), .mem_read_data(c_mrd),
        .mem_write_valid(c_mwv), .mem_write_address(c_mwa),
        .mem_write_data(c_mwd), .mem_write_ready(c_mwr)
    );

    // One-pulse responder: ready one cycle after valid, never two cycles in a row
    always @(posedge clk) begin
        if (reset) begin
            a_mrr <= '0; a_mwr <= '0; b_mrr <= '0; b_mwr <= '0; c_mrr <= '0; c_mwr <= '0;
            a_mrd <= '0; b_mrd <= '0; c_mrd <= '0;
            a_reads <= 0;
            mem[8'h10] <= 16'h00AB;
            mem[8'h20] <= 16'h0000;
            mem[8'h21] <= 16'h0000;
            mem[8'h30] <= 16'h1234;
            mem[8'h31] <= 16'h5678;
            mem[8'h32] <= 16'h9ABC;
            mem[8'h33] <= 16'hDEF0;
        end else begin
            a_mrr[0] <= a_mrv[0] && !a_mrr[0] && !a_stall;
            if (a_mrv[0] && !a_mrr[0] && !a_stall) begin
                a_mrd[0] <= mem[a_mra[0]];
                a_log[a_reads[7:0]] <= a_mra[0];
                a_reads <= a_reads + 1;
            end
            a_mwr[0] <= a_mwv[0] && !a_mwr[0];
            if (a_mwv[0] && !a_mwr[0]) mem[a_mwa[0]] <= a_mwd[0];
            for (int c = 0; c < 2; c++) begin
                b_mrr[c] <= b_mrv[c] && !b_mrr[c];
                if (b_mrv[c] && !b_mrr[c]) b_mrd[c] <= mem[b_mra[c]];
                b_mwr[c] <= b_mwv[c] && !b_mwr[c];
                if (b_mwv[c] && !b_mwr[c]) mem[b_mwa[c]] <= b_mwd[c];
            end
            c_mrr[0] <= c_mrv[0] && !c_mrr[0];
            if (c_mrv[0] && !c_mrr[0]) c_mrd[0] <= mem[c_mra[0]];
            c_mwr[0] <= c_mwv[0] && !c_mwr[0];
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0; a_stall = 1'b0;
        b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0;
        c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_a_rr(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (a_rr[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [7:0]  t2_order [4] = '{8'h31, 8'h32, 8'h33, 8'h30};
    logic [15:0] t2_exp   [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    logic [15:0] t2_got   [4];

    initial begin
        bit ok;
        int base, held, overlap, bad_v, bad_r, bad_m;

        // Reset state
        do_reset();
        check_eq("rst_a_mrv", 32'(a_mrv), 0);
        check_eq("rst_a_rr",  32'(a_rr), 0);
        check_eq("rst_a_wr",  32'(a_wr), 0);
        check_eq("rst_a_mwv", 32'(a_mwv), 0);
        check_eq("rst_b_mwv", 32'(b_mwv), 0);

        // Single read by consumer 2, cycle-by-cycle
        a_ra[2] = 8'h10; a_rv[2] = 1'b1;
        @(negedge clk);
        check_eq("t1_mrv",      32'(a_mrv), 1);
        check_eq("t1_mra",      32'(a_mra[0]), 32'h10);
        check_eq("t1_rr_early", 32'(a_rr), 0);
        @(negedge clk);
        check_eq("t1_mrr",      32'(a_mrr), 1);
        @(negedge clk);
        check_eq("t1_mrv_drop", 32'(a_mrv), 0);
        check_eq("t1_rr",       32'(a_rr), 32'b0100);
        check_eq("t1_rd",       32'(a_rd[2]), 32'hAB);
        a_rv[2] = 1'b0;
        @(negedge clk);
        check_eq("t1_rr_clear", 32'(a_rr), 0);
        check_eq("t1_rd_hold",  32'(a_rd[2]), 32'hAB);

        // All four consumers read at once on one channel
        do_reset();
        base = a_reads;
        overlap = 0;
        for (int i = 0; i < 4; i++) begin
            a_ra[i] = 8'h30 + 8'(i);
            t2_got[i] = '0;
        end
        a_rv = 4'hF;
        for (int k = 0; k < 60 && a_rv != 4'h0; k++) begin
            @(negedge clk);
            if ($countones(a_rr) > 1) overlap++;
            for (int i = 0; i < 4; i++) begin
                if (a_rr[i] && a_rv[i]) begin
                    t2_got[i] = a_rd[i];
                    a_rv[i] = 1'b0;
                end
            end
        end
        repeat (2) @(negedge clk);
        check_eq("t2_all_served", 32'(a_rv), 0);
        check_eq("t2_reads", 32'(a_reads - base), 4);
        check_eq("t2_overlap", 32'(overlap), 0);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t2_order%0d", k), 32'(a_log[8'(base + k)]), 32'(t2_order[k]));
            check_eq($sformatf("t2_data%0d", k), 32'(t2_got[k]), 32'(t2_exp[k]));
        end

        // Consumer holds valid 5 cycles after ready
        do_reset();
        base = a_reads;
        a_ra[0] = 8'h10; a_rv[0] = 1'b1;
        wait_a_rr(0, 10, ok);
        check_eq("t4_ready_seen", 32'(ok), 1);
        held = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_rr[0]) held++;
        end
        check_eq("t4_held", 32'(held), 5);
        a_rv[0] = 1'b0;
        @(negedge clk);
        check_eq("t4_rr_clear", 32'(a_rr[0]), 0);
        check_eq("t4_reads", 32'(a_reads - base), 1);
        check_eq("t4_data", 32'(a_rd[0]), 32'hAB);

        // Reset while READ_WAITING, then the same request succeeds
        do_reset();
        a_stall = 1'b1;
        a_ra[1] = 8'h10; a_rv[1] = 1'b1;
        @(negedge clk);
        check_eq("t5_mrv", 32'(a_mrv), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_mrv", 32'(a_mrv), 0);
        check_eq("t5_rst_rr",  32'(a_rr), 0);
        reset = 1'b0;
        a_stall = 1'b0;
        wait_a_rr(1, 10, ok);
        check_eq("t5_reissue_ready", 32'(ok), 1);
        check_eq("t5_reissue_data", 32'(a_rd[1]), 32'hAB);
        a_rv[1] = 1'b0;
        @(negedge clk);

        // Two channels serve writes from consumers 0 and 3 in parallel
        do_reset();
        b_wa[0] = 8'h20; b_wd[0] = 16'h005A;
        b_wa[3] = 8'h21; b_wd[3] = 16'h00C3;
        b_wv = 4'b1001;
        @(negedge clk);
        check_eq("t3_mwv",      32'(b_mwv), 32'b11);
        check_eq("t3_ch0_addr", 32'(b_mwa[0]), 32'h21);
        check_eq("t3_ch1_addr", 32'(b_mwa[1]), 32'h20);
        @(negedge clk);
        @(negedge clk);
        check_eq("t3_wr",       32'(b_wr), 32'b1001);
        check_eq("t3_mwv_drop", 32'(b_mwv), 0);
        repeat (2) @(negedge clk);
        check_eq("t3_wr_hold",  32'(b_wr), 32'b1001);
        b_wv[0] = 1'b0;
        @(negedge clk);
        check_eq("t3_wr_c0_drop", 32'(b_wr), 32'b1000);
        b_wv[3] = 1'b0;
        @(negedge clk);
        check_eq("t3_wr_c3_drop", 32'(b_wr), 0);
        check_eq("t3_mem20", 32'(mem[8'h20]), 32'h5A);
        check_eq("t3_mem21", 32'(mem[8'h21]), 32'hC3);

        // Read-only instance ignores write requests
        do_reset();
        c_wa[1] = 8'h40; c_wd[1] = 16'h0001; c_wv[1] = 1'b1;
        bad_v = 0; bad_r = 0; bad_m = 0;
        repeat (20) begin
            @(negedge clk);
            if (c_mwv != '0) bad_v++;
            if (c_wr != '0) bad_r++;
            if (c_mrv != '0) bad_m++;
        end
        check_eq("t6_mwv_quiet", 32'(bad_v), 0);
        check_eq("t6_wr_quiet",  32'(bad_r), 0);
        check_eq("t6_mrv_quiet", 32'(bad_m), 0);
        c_ra[0] = 8'h10; c_rv[0] = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_read_rr", 32'(c_rr), 32'b0001);
        check_eq("t6_read_rd", 32'(c_rd[0]), 32'hAB);
        c_rv[0] = 1'b0;
        c_wv[1] = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
